// File: rtl/csa_pipe_adder_if.sv
// Handshake and operand/result bus for csa_pipe_adder.
// Upstream side:   i_valid, i_add_term1, i_add_term2, i_cin, i_sub -> o_ready
// Downstream side: o_valid, o_sum, o_cout, o_ovf -> i_ready
// master: the environment that drives operands and accepts results
// slave:  the adder itself
interface csa_pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_add_term1;
  logic [WIDTH-1:0] i_add_term2;
  logic             i_cin;
  logic             i_sub;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_ovf;

  modport master (
    output i_valid, i_add_term1, i_add_term2, i_cin, i_sub, i_ready,
    input  o_ready, o_valid, o_sum, o_cout, o_ovf
  );

  modport slave (
    input  i_valid, i_add_term1, i_add_term2, i_cin, i_sub, i_ready,
    output o_ready, o_valid, o_sum, o_cout, o_ovf
  );
endinterface

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready handshake.
// Operands are cut into BLOCK-bit segments (last one may be partial). Segment 0
// ripples; every higher segment computes both carry-in results and selects.
// Segments are distributed over STAGES register stages; latency = STAGES.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      csa_pipe_adder_if.slave: operands (A, B, cin, sub) with
//            i_valid/o_ready in, result (sum, cout, ovf) with o_valid/i_ready out
module csa_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input logic               i_clk,
  input logic               i_rst_n,
  csa_pipe_adder_if.slave   bus
);

  localparam int NB   = (WIDTH + BLOCK - 1) / BLOCK;
  localparam int LAST = STAGES - 1;

  // First segment handled by stage s; stage s owns [seg_lo(s), seg_lo(s+1)).
  function automatic int seg_lo(input int s);
    return (s * NB) / STAGES;
  endfunction

  function automatic int stage_of(input int k);
    int r;
    r = 0;
    for (int unsigned s = 0; s < STAGES; s++)
      if (k >= seg_lo(int'(s))) r = int'(s);
    return r;
  endfunction

  // Stage registers: valid, operands (B already conditioned for subtract),
  // partially resolved sum, and the carry leaving the stage's last segment.
  logic             vld_q [STAGES];
  logic             vld_d [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic             c_q   [STAGES];
  logic             c_d   [STAGES];

  // Values presented to each stage's combinational logic.
  logic             st_vld [STAGES];
  logic [WIDTH-1:0] st_a   [STAGES];
  logic [WIDTH-1:0] st_b   [STAGES];
  logic [WIDTH-1:0] st_sum [STAGES];
  logic             st_c   [STAGES];

  logic             seg_co  [NB];
  logic [WIDTH-1:0] seg_val [NB];
  logic             en;

  assign en = !vld_q[LAST] || bus.i_ready;

  always_comb begin
    st_vld[0] = bus.i_valid;
    st_a[0]   = bus.i_add_term1;
    st_b[0]   = bus.i_add_term2 ^ {WIDTH{bus.i_sub}};
    st_c[0]   = bus.i_sub | bus.i_cin;
    st_sum[0] = '0;
    for (int unsigned s = 1; s < STAGES; s++) begin
      st_vld[s] = vld_q[s-1];
      st_a[s]   = a_q[s-1];
      st_b[s]   = b_q[s-1];
      st_c[s]   = c_q[s-1];
      st_sum[s] = sum_q[s-1];
    end
  end

  for (genvar k = 0; k < NB; k++) begin : g_seg
    localparam int LO = k * BLOCK;
    localparam int HI = ((k + 1) * BLOCK < WIDTH) ? (k + 1) * BLOCK - 1 : WIDTH - 1;
    localparam int W  = HI - LO + 1;
    localparam int SK = stage_of(k);

    logic [W-1:0] a_seg;
    logic [W-1:0] b_seg;
    logic         ci;
    logic         co;
    logic [W:0]   res;

    assign a_seg = st_a[SK][HI:LO];
    assign b_seg = st_b[SK][HI:LO];

    // A segment opening a stage takes the carry registered by the previous
    // stage (or the effective carry-in for stage 0); otherwise it chains.
    if (k == seg_lo(SK)) begin : g_first
      assign ci = st_c[SK];
    end else begin : g_chain
      assign ci = g_seg[k-1].co;
    end

    if (k == 0) begin : g_ripple
      assign res = {1'b0, a_seg} + {1'b0, b_seg} + {{W{1'b0}}, ci};
    end else begin : g_select
      logic [W:0] res0;
      logic [W:0] res1;
      assign res0 = {1'b0, a_seg} + {1'b0, b_seg};
      assign res1 = {1'b0, a_seg} + {1'b0, b_seg} + {{W{1'b0}}, 1'b1};
      assign res  = ci ? res1 : res0;
    end

    assign co         = res[W];
    assign seg_co[k]  = co;
    assign seg_val[k] = WIDTH'(res[W-1:0]) << LO;
  end

  // Unresolved sum bits are always zero, so each stage ORs in its segments.
  always_comb begin
    for (int unsigned s = 0; s < STAGES; s++) begin
      vld_d[s] = vld_q[s];
      a_d[s]   = a_q[s];
      b_d[s]   = b_q[s];
      c_d[s]   = c_q[s];
      sum_d[s] = sum_q[s];
      if (en) begin
        vld_d[s] = st_vld[s];
        a_d[s]   = st_a[s];
        b_d[s]   = st_b[s];
        sum_d[s] = st_sum[s];
        for (int unsigned k = 0; k < NB; k++)
          if (int'(k) >= seg_lo(int'(s)) && int'(k) < seg_lo(int'(s) + 1))
            sum_d[s] = sum_d[s] | seg_val[k];
        c_d[s] = seg_co[seg_lo(int'(s) + 1) - 1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        vld_q[s] <= 1'b0;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        c_q[s]   <= 1'b0;
        sum_q[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        vld_q[s] <= vld_d[s];
        a_q[s]   <= a_d[s];
        b_q[s]   <= b_d[s];
        c_q[s]   <= c_d[s];
        sum_q[s] <= sum_d[s];
      end
    end
  end

  assign bus.o_ready = en;
  assign bus.o_valid = vld_q[LAST];
  assign bus.o_sum   = sum_q[LAST];
  assign bus.o_cout  = c_q[LAST];
  assign bus.o_ovf   = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                       (sum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_csa_pipe_adder.sv
module tb_csa_pipe_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csa_pipe_adder_if #(.WIDTH(32)) bus32 ();
  csa_pipe_adder_if #(.WIDTH(13)) bus13 ();

  csa_pipe_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus32.slave));
  csa_pipe_adder #(.WIDTH(13), .BLOCK(4), .STAGES(3)) u_dut13 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus13.slave));

  int n_checks = 0;
  int n_fail   = 0;
  longint unsigned q32[$];
  longint unsigned q13[$];

  // Reference: plain integer arithmetic. Packs {ovf, cout, sum[w-1:0]}.
  function automatic longint unsigned model(int w, longint unsigned a, longint unsigned b,
                                            bit cin, bit sub);
    longint unsigned m, sum, tot;
    longint sa, sb, sr, lim;
    bit cout, ovf;
    m   = (64'd1 << w) - 64'd1;
    lim = longint'(64'd1 << (w - 1));
    sa  = (a >= 64'(lim)) ? longint'(a) - 2 * lim : longint'(a);
    sb  = (b >= 64'(lim)) ? longint'(b) - 2 * lim : longint'(b);
    if (sub) begin
      sum  = (a - b) & m;
      cout = (a >= b);
      sr   = sa - sb;
    end else begin
      tot  = a + b + 64'(cin);
      sum  = tot & m;
      cout = (tot >> w) != 0;
      sr   = sa + sb + longint'(cin);
    end
    ovf = (sr >= lim) || (sr < -lim);
    return (64'(ovf) << (w + 1)) | (64'(cout) << w) | sum;
  endfunction

  task automatic idle_all();
    bus32.i_valid = 0; bus32.i_ready = 1; bus32.i_cin = 0; bus32.i_sub = 0;
    bus32.i_add_term1 = '0; bus32.i_add_term2 = '0;
    bus13.i_valid = 0; bus13.i_ready = 1; bus13.i_cin = 0; bus13.i_sub = 0;
    bus13.i_add_term1 = '0; bus13.i_add_term2 = '0;
  endtask

  // Presents one operation to the 32-bit adder and returns the number of
  // rising edges until o_valid (-1 if it never shows). No checking here.
  task automatic drive32(input logic [31:0] a, input logic [31:0] b,
                         input bit cin, input bit sub, output int lat);
    @(negedge clk);
    bus32.i_add_term1 = a; bus32.i_add_term2 = b;
    bus32.i_cin = cin; bus32.i_sub = sub;
    bus32.i_valid = 1; bus32.i_ready = 1;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus32.i_valid = 0;
      if (bus32.o_valid) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 0;
    #12;
    n_checks++; if (bus32.o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid32: got %b want 0", bus32.o_valid); end
    n_checks++; if (bus32.o_sum !== 32'h0) begin n_fail++; $display("FAIL rst_sum32: got %h want 0", bus32.o_sum); end
    n_checks++; if ({bus32.o_cout, bus32.o_ovf} !== 2'b00) begin n_fail++; $display("FAIL rst_flags32: got %b want 00", {bus32.o_cout, bus32.o_ovf}); end
    n_checks++; if (bus13.o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid13: got %b want 0", bus13.o_valid); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    n_checks++; if (bus32.o_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready32: got %b want 1", bus32.o_ready); end
    n_checks++; if (bus32.o_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid32: got %b want 0", bus32.o_valid); end
    n_checks++; if (bus32.o_sum !== 32'h0) begin n_fail++; $display("FAIL idle_sum32: got %h want 0", bus32.o_sum); end
  endtask

  task automatic test_add_wrap();
    int lat;
    drive32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL add_wrap_latency: got %0d want 2", lat); end
    n_checks++; if ({bus32.o_ovf, bus32.o_cout, bus32.o_sum} !== {1'b0, 1'b1, 32'h0})
      begin n_fail++; $display("FAIL add_wrap: got ovf=%b cout=%b sum=%h want 0 1 00000000", bus32.o_ovf, bus32.o_cout, bus32.o_sum); end
    drive32(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, lat);
    n_checks++; if ({bus32.o_ovf, bus32.o_cout, bus32.o_sum} !== {1'b0, 1'b0, 32'h4})
      begin n_fail++; $display("FAIL add_cin: got ovf=%b cout=%b sum=%h want 0 0 00000004", bus32.o_ovf, bus32.o_cout, bus32.o_sum); end
  endtask

  task automatic test_sub_ovf();
    int lat;
    drive32(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, lat);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL sub_latency: got %0d want 2", lat); end
    n_checks++; if ({bus32.o_ovf, bus32.o_cout, bus32.o_sum} !== {1'b1, 1'b1, 32'h7FFF_FFFF})
      begin n_fail++; $display("FAIL sub_ovf: got ovf=%b cout=%b sum=%h want 1 1 7fffffff", bus32.o_ovf, bus32.o_cout, bus32.o_sum); end
    drive32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
    n_checks++; if ({bus32.o_ovf, bus32.o_cout, bus32.o_sum} !== {1'b1, 1'b0, 32'h8000_0000})
      begin n_fail++; $display("FAIL add_ovf: got ovf=%b cout=%b sum=%h want 1 0 80000000", bus32.o_ovf, bus32.o_cout, bus32.o_sum); end
    // Subtract with cin=1: carry-in must be ignored in subtract mode.
    drive32(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, lat);
    n_checks++; if ({bus32.o_ovf, bus32.o_cout, bus32.o_sum} !== {1'b0, 1'b0, 32'hFFFF_FFFF})
      begin n_fail++; $display("FAIL sub_borrow: got ovf=%b cout=%b sum=%h want 0 0 ffffffff", bus32.o_ovf, bus32.o_cout, bus32.o_sum); end
  endtask

  task automatic test_back_to_back();
    int got, first, last;
    longint unsigned e;
    logic [33:0] obs;
    got = 0; first = -1; last = -1;
    q32.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus32.i_ready = 1;
      if (c < 8) begin
        bus32.i_add_term1 = $urandom; bus32.i_add_term2 = $urandom;
        bus32.i_cin = 1'($urandom_range(0, 1)); bus32.i_sub = 0; bus32.i_valid = 1;
        q32.push_back(model(32, 64'(bus32.i_add_term1), 64'(bus32.i_add_term2), bus32.i_cin, 1'b0));
      end else bus32.i_valid = 0;
      @(posedge clk); #1;
      if (bus32.o_valid) begin
        obs = {bus32.o_ovf, bus32.o_cout, bus32.o_sum};
        n_checks++;
        if (q32.size() == 0) begin n_fail++; $display("FAIL b2b_extra: got sum=%h want no result", bus32.o_sum); end
        else begin
          e = q32.pop_front();
          if (obs !== 34'(e)) begin n_fail++; $display("FAIL b2b_data: got %h want %h", obs, 34'(e)); end
        end
        got++; if (first < 0) first = c; last = c;
      end
    end
    n_checks++; if (got != 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", got); end
    n_checks++; if (first != 1) begin n_fail++; $display("FAIL b2b_first: got %0d want 1", first); end
    n_checks++; if (last - first != 7) begin n_fail++; $display("FAIL b2b_consecutive: got span %0d want 7", last - first); end
  endtask

  task automatic test_stall();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] held;
    logic [33:0] obs;
    longint unsigned e;
    int idx, got;
    idx = 0; got = 0; held = '0;
    q32.delete();
    for (int i = 0; i < 4; i++) begin va[i] = $urandom; vb[i] = $urandom; end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      bus32.i_ready = (c >= 5);
      if (idx < 4) begin
        bus32.i_valid = 1; bus32.i_add_term1 = va[idx]; bus32.i_add_term2 = vb[idx];
        bus32.i_cin = 0; bus32.i_sub = idx[0];
      end else bus32.i_valid = 0;
      #1;
      if (c >= 2 && c < 5) begin
        n_checks++; if (bus32.o_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready c%0d: got %b want 0", c, bus32.o_ready); end
        n_checks++; if (bus32.o_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid c%0d: got %b want 1", c, bus32.o_valid); end
        if (c == 2) held = bus32.o_sum;
        else begin
          n_checks++; if (bus32.o_sum !== held) begin n_fail++; $display("FAIL stall_hold c%0d: got %h want %h", c, bus32.o_sum, held); end
        end
      end
      if (bus32.o_valid && bus32.i_ready) begin
        obs = {bus32.o_ovf, bus32.o_cout, bus32.o_sum};
        n_checks++;
        if (q32.size() == 0) begin n_fail++; $display("FAIL stall_dup: got sum=%h want no result", bus32.o_sum); end
        else begin
          e = q32.pop_front();
          if (obs !== 34'(e)) begin n_fail++; $display("FAIL stall_data: got %h want %h", obs, 34'(e)); end
        end
        got++;
      end
      if (bus32.i_valid && bus32.o_ready) begin
        q32.push_back(model(32, 64'(va[idx]), 64'(vb[idx]), 1'b0, idx[0]));
        idx++;
      end
      @(posedge clk);
    end
    n_checks++; if (got != 4 || idx != 4) begin n_fail++; $display("FAIL stall_count: got %0d/%0d want 4/4", got, idx); end
  endtask

  task automatic test_random13();
    int sent;
    bit did_rst;
    longint unsigned e;
    logic [14:0] obs;
    sent = 0; did_rst = 0;
    q13.delete();
    for (int c = 0; c < 40000 && sent < 10000; c++) begin
      @(negedge clk);
      if (sent >= 5000 && !did_rst) begin
        did_rst = 1;
        rst_n = 0; bus13.i_valid = 0;
        #1;
        n_checks++; if (bus13.o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", bus13.o_valid); end
        n_checks++; if (bus13.o_sum !== 13'h0) begin n_fail++; $display("FAIL midrst_sum: got %h want 0", bus13.o_sum); end
        q13.delete();
        @(negedge clk); rst_n = 1;
        for (int p = 0; p < 3; p++) begin
          @(posedge clk); #1;
          n_checks++; if (bus13.o_valid !== 1'b0) begin n_fail++; $display("FAIL postrst_valid p%0d: got %b want 0", p, bus13.o_valid); end
        end
        n_checks++; if (bus13.o_ready !== 1'b1) begin n_fail++; $display("FAIL postrst_ready: got %b want 1", bus13.o_ready); end
        continue;
      end
      bus13.i_ready = ($urandom_range(0, 3) != 0);
      bus13.i_valid = ($urandom_range(0, 7) != 0);
      bus13.i_add_term1 = 13'($urandom_range(0, 8191));
      bus13.i_add_term2 = 13'($urandom_range(0, 8191));
      bus13.i_cin = 1'($urandom_range(0, 1));
      bus13.i_sub = 1'($urandom_range(0, 1));
      #1;
      if (bus13.o_valid && bus13.i_ready) begin
        obs = {bus13.o_ovf, bus13.o_cout, bus13.o_sum};
        n_checks++;
        if (q13.size() == 0) begin n_fail++; $display("FAIL rand13_extra: got sum=%h want no result", bus13.o_sum); end
        else begin
          e = q13.pop_front();
          if (obs !== 15'(e)) begin n_fail++; $display("FAIL rand13_data: got %h want %h", obs, 15'(e)); end
        end
      end
      if (bus13.i_valid && bus13.o_ready) begin
        q13.push_back(model(13, 64'(bus13.i_add_term1), 64'(bus13.i_add_term2), bus13.i_cin, bus13.i_sub));
        sent++;
      end
      @(posedge clk);
    end
    n_checks++; if (sent != 10000) begin n_fail++; $display("FAIL rand13_sent: got %0d want 10000", sent); end
    for (int c = 0; c < 50 && q13.size() > 0; c++) begin
      @(negedge clk);
      bus13.i_valid = 0; bus13.i_ready = 1;
      #1;
      if (bus13.o_valid) begin
        obs = {bus13.o_ovf, bus13.o_cout, bus13.o_sum};
        e = q13.pop_front();
        n_checks++; if (obs !== 15'(e)) begin n_fail++; $display("FAIL rand13_drain: got %h want %h", obs, 15'(e)); end
      end
      @(posedge clk);
    end
    n_checks++; if (q13.size() != 0) begin n_fail++; $display("FAIL rand13_lost: got %0d pending want 0", q13.size()); end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_add_wrap();
    test_sub_ovf();
    test_back_to_back();
    test_stall();
    test_random13();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
